// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port (optional macro MEM_ARBITER_ROUND_ROBIN_EN).
// Latency: grant on the edge after a request is seen in IDLE; ack as early as the first BUSY cycle; one IDLE cycle between transactions.
// Backpressure: requesters hold req until their ack pulse; stall is raised while any request is still unacknowledged.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,

    // instruction-fetch port (read-only)
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_err,

    // data port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [3:0]            d_sel,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,

    // shared memory port
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [3:0]            m_sel,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ack,
    input  logic [DATA_WIDTH-1:0] m_rdata,

    output logic                  stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Wait-counter value at which the current transaction is abandoned with an error.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       timeout_hit;
    logic       finish;
    logic       grant_d;
    logic       grant_i;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // 1 = data wins the next simultaneous request; reset favours data and every
    // grant hands priority to the other requester.
    logic       prefer_d;
`endif

    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
    assign finish      = (state != IDLE) && (m_ack || timeout_hit);

    // Grant decision for the IDLE cycle.
    always_comb begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        grant_d = d_req && (!i_req || prefer_d);
`else
        grant_d = d_req;
`endif
        grant_i = i_req && !grant_d;
    end

    // Arbitration FSM with latched memory-port fields and wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_sel    <= 4'h0;
            m_wdata  <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            prefer_d <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // m_ack seen here belongs to no transaction and is ignored.
                    if (grant_d) begin
                        state    <= BUSY_D;
                        wait_cnt <= 8'd0;
                        m_req    <= 1'b1;
                        m_we     <= d_we;
                        m_addr   <= d_addr;
                        m_sel    <= d_sel;
                        m_wdata  <= d_wdata;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        prefer_d <= 1'b0;
`endif
                    end else if (grant_i) begin
                        state    <= BUSY_I;
                        wait_cnt <= 8'd0;
                        m_req    <= 1'b1;
                        m_we     <= 1'b0;
                        m_addr   <= i_addr;
                        m_sel    <= 4'hF;
                        m_wdata  <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        prefer_d <= 1'b1;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    // The transaction runs to completion even if the requester drops req.
                    if (finish) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

    // Response steering: ack is a single-cycle pulse, a real m_ack beats a
    // coincident timeout, and rdata is zero whenever no ack carries data.
    always_comb begin
        i_ack   = 1'b0;
        i_err   = 1'b0;
        i_rdata = '0;
        d_ack   = 1'b0;
        d_err   = 1'b0;
        d_rdata = '0;
        if (state == BUSY_I) begin
            i_ack   = m_ack || timeout_hit;
            i_err   = !m_ack && timeout_hit;
            i_rdata = m_ack ? m_rdata : '0;
        end else if (state == BUSY_D) begin
            d_ack   = m_ack || timeout_hit;
            d_err   = !m_ack && timeout_hit;
            d_rdata = m_ack ? m_rdata : '0;
        end
    end

    // Pipeline stall while any request is outstanding.
    always_comb begin
        stall = (i_req && !i_ack) || (d_req && !d_ack);
    end

endmodule
